// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, ALUOp encodings and the issue-buffer entry layout.
package alu_pkg;

    localparam int XLEN   = 64;
    localparam int CTRL_W = 4;

    localparam logic [CTRL_W-1:0] ALU_AND = 4'b0000;
    localparam logic [CTRL_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [CTRL_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [CTRL_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [CTRL_W-1:0] ALU_NOR = 4'b1100;
    localparam logic [CTRL_W-1:0] ALU_ILL = 4'b1111;

    localparam logic [1:0] ALUOP_LDST  = 2'b00;
    localparam logic [1:0] ALUOP_BEQ   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_NOR   = 2'b11;

    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_OR     = 3'b110;
    localparam logic [2:0] F3_AND    = 3'b111;

    typedef struct packed {
        logic [XLEN-1:0]   a;
        logic [XLEN-1:0]   b;
        logic [CTRL_W-1:0] control;
        logic              illegal;
    } alu_entry_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU control decode from (ALUOp, funct3, funct7 bit 30).
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [1:0]        alu_op,
    input  logic [2:0]        funct3,
    input  logic              funct7_b30,
    output logic [CTRL_W-1:0] control,
    output logic              illegal
);

    always_comb begin
        control = ALU_ILL;
        illegal = 1'b0;
        case (alu_op)
            ALUOP_LDST: control = ALU_ADD;
            ALUOP_BEQ:  control = ALU_SUB;
            ALUOP_NOR:  control = ALU_NOR;
            default: begin
                case (funct3)
                    F3_ADDSUB: control = funct7_b30 ? ALU_SUB : ALU_ADD;
                    F3_AND:    control = ALU_AND;
                    F3_OR:     control = ALU_OR;
                    // unsupported R-type ops flow to the ALU as 1111, which it resolves to 0
                    default: begin
                        control = ALU_ILL;
                        illegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID->EX issue stage: decode, operand-B select and a 2-entry valid/ready elastic buffer.
// Optional performance counters are enabled with the ALU_ISSUE_PERF_EN macro.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int CTRL_WIDTH = CTRL_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            alu_op,
    input  logic [2:0]            funct3,
    input  logic                  funct7_b30,
    input  logic                  alu_src,
    input  logic [DATA_WIDTH-1:0] rs1_data,
    input  logic [DATA_WIDTH-1:0] rs2_data,
    input  logic [DATA_WIDTH-1:0] imm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_a,
    output logic [DATA_WIDTH-1:0] out_b,
    output logic [CTRL_WIDTH-1:0] out_control,
`ifdef ALU_ISSUE_PERF_EN
    output logic [31:0]           issue_count,
    output logic [31:0]           stall_count,
`endif
    output logic                  out_illegal
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t                state, state_nxt;
    alu_entry_t            entry_in, entry_p0, entry_p1;
    logic [CTRL_WIDTH-1:0] dec_control;
    logic                  dec_illegal;
    logic                  push, pop;
    logic                  ld_head_in, ld_head_tail, ld_tail;

    alu_ctrl_decode u_dec (
        .alu_op     (alu_op),
        .funct3     (funct3),
        .funct7_b30 (funct7_b30),
        .control    (dec_control),
        .illegal    (dec_illegal)
    );

    assign entry_in = '{a:       rs1_data,
                        b:       alu_src ? imm : rs2_data,
                        control: dec_control,
                        illegal: dec_illegal};

    // Handshake flags depend on the state register alone, so there is no in->out ready path.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= EMPTY;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        ld_head_in   = 1'b0;
        ld_head_tail = 1'b0;
        ld_tail      = 1'b0;
        case (state)
            EMPTY: begin
                if (push) begin
                    state_nxt  = ONE;
                    ld_head_in = 1'b1;
                end
            end
            ONE: begin
                if (push && pop) begin
                    ld_head_in = 1'b1;
                end else if (push) begin
                    state_nxt = FULL;
                    ld_tail   = 1'b1;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_nxt    = ONE;
                    ld_head_tail = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // ---- buffer stage: p0 is the head presented to EX, p1 the waiting entry
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            entry_p0 <= '0;
            entry_p1 <= '0;
        end else begin
            if (ld_head_in)        entry_p0 <= entry_in;
            else if (ld_head_tail) entry_p0 <= entry_p1;
            if (ld_tail)           entry_p1 <= entry_in;
        end
    end

    assign out_a       = entry_p0.a;
    assign out_b       = entry_p0.b;
    assign out_control = entry_p0.control;
    assign out_illegal = entry_p0.illegal;

`ifdef ALU_ISSUE_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            issue_count <= '0;
            stall_count <= '0;
        end else begin
            if (pop)                    issue_count <= issue_count + 32'd1;
            if (out_valid && !out_ready) stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed, table-driven bench for alu_issue_stage (define ALU_ISSUE_PERF_EN to cover the counters).
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready;
    logic [1:0]  alu_op;
    logic [2:0]  funct3;
    logic        funct7_b30, alu_src;
    logic [63:0] rs1_data, rs2_data, imm;
    logic        out_valid, out_ready;
    logic [63:0] out_a, out_b;
    logic [3:0]  out_control;
    logic        out_illegal;
`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] issue_count, stall_count;
    logic [31:0] issue_base, stall_base;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7_b30  (funct7_b30),
        .alu_src     (alu_src),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .imm         (imm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_control (out_control),
`ifdef ALU_ISSUE_PERF_EN
        .issue_count (issue_count),
        .stall_count (stall_count),
`endif
        .out_illegal (out_illegal)
    );

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  f3;
        logic        b30;
        logic        src;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [63:0] im;
        logic [3:0]  ctl;
        logic        ill;
        logic [63:0] a;
        logic [63:0] b;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Independent expected-control table: {control, illegal}
    function automatic logic [4:0] ref_dec(input logic [1:0] op, input logic [2:0] f3, input logic b30);
        if (op == 2'b00) return 5'b0010_0;
        if (op == 2'b01) return 5'b0110_0;
        if (op == 2'b11) return 5'b1100_0;
        if (f3 == 3'b000 && !b30) return 5'b0010_0;
        if (f3 == 3'b000 &&  b30) return 5'b0110_0;
        if (f3 == 3'b111) return 5'b0000_0;
        if (f3 == 3'b110) return 5'b0001_0;
        return 5'b1111_1;
    endfunction

    initial begin
        vt[0]  = '{2'b00, 3'b011, 1'b0, 1'b1, 64'h100, 64'hAA, 64'h8,  4'b0010, 1'b0, 64'h100, 64'h8};
        vt[1]  = '{2'b01, 3'b000, 1'b0, 1'b0, 64'h7,   64'h9,  64'h0,  4'b0110, 1'b0, 64'h7,   64'h9};
        vt[2]  = '{2'b11, 3'b010, 1'b1, 1'b0, 64'h1,   64'h2,  64'h3,  4'b1100, 1'b0, 64'h1,   64'h2};
        vt[3]  = '{2'b10, 3'b000, 1'b0, 1'b0, 64'h10,  64'h20, 64'h30, 4'b0010, 1'b0, 64'h10,  64'h20};
        vt[4]  = '{2'b10, 3'b000, 1'b1, 1'b0, 64'h11,  64'h21, 64'h31, 4'b0110, 1'b0, 64'h11,  64'h21};
        vt[5]  = '{2'b10, 3'b111, 1'b1, 1'b0, 64'hF0,  64'h0F, 64'h0,  4'b0000, 1'b0, 64'hF0,  64'h0F};
        vt[6]  = '{2'b10, 3'b110, 1'b0, 1'b0, 64'hA,   64'h5,  64'h0,  4'b0001, 1'b0, 64'hA,   64'h5};
        vt[7]  = '{2'b10, 3'b001, 1'b0, 1'b0, 64'h3,   64'h4,  64'h0,  4'b1111, 1'b1, 64'h3,   64'h4};
        vt[8]  = '{2'b10, 3'b101, 1'b1, 1'b0, 64'h6,   64'h7,  64'h0,  4'b1111, 1'b1, 64'h6,   64'h7};
        vt[9]  = '{2'b00, 3'b000, 1'b0, 1'b1, 64'h5,   64'h3,  64'hFFFF_FFFF_FFFF_FFF0, 4'b0010, 1'b0, 64'h5, 64'hFFFF_FFFF_FFFF_FFF0};
        vt[10] = '{2'b00, 3'b000, 1'b0, 1'b0, 64'h5,   64'h3,  64'hFFFF_FFFF_FFFF_FFF0, 4'b0010, 1'b0, 64'h5, 64'h3};

        // Reset held with random stimulus
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid   = 1'($urandom);
            out_ready  = 1'($urandom);
            alu_op     = 2'($urandom);
            funct3     = 3'($urandom);
            funct7_b30 = 1'($urandom);
            alu_src    = 1'($urandom);
            rs1_data   = {$urandom, $urandom};
            rs2_data   = {$urandom, $urandom};
            imm        = {$urandom, $urandom};
            step();
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 1);
            chk("rst_control", out_control, 0);
            chk("rst_a", out_a, 0);
            chk("rst_illegal", out_illegal, 0);
        end
`ifdef ALU_ISSUE_PERF_EN
        chk("rst_issue_count", issue_count, 0);
        chk("rst_stall_count", stall_count, 0);
`endif
        in_valid  = 1'b0;
        out_ready = 1'b1;
        reset_n   = 1'b1;
        step();
        chk("idle_out_valid", out_valid, 0);

        // Directed decode / operand-mux table, streamed with out_ready=1
        for (int i = 0; i < 11; i++) begin
            in_valid   = 1'b1;
            alu_op     = vt[i].op;
            funct3     = vt[i].f3;
            funct7_b30 = vt[i].b30;
            alu_src    = vt[i].src;
            rs1_data   = vt[i].rs1;
            rs2_data   = vt[i].rs2;
            imm        = vt[i].im;
            step();
            chk($sformatf("vec%0d_valid", i), out_valid, 1);
            chk($sformatf("vec%0d_control", i), out_control, vt[i].ctl);
            chk($sformatf("vec%0d_illegal", i), out_illegal, vt[i].ill);
            chk($sformatf("vec%0d_a", i), out_a, vt[i].a);
            chk($sformatf("vec%0d_b", i), out_b, vt[i].b);
        end

        // Full decode sweep
        for (int op = 0; op < 4; op++)
            for (int f = 0; f < 8; f++)
                for (int b = 0; b < 2; b++) begin
                    logic [4:0] e;
                    e          = ref_dec(2'(op), 3'(f), 1'(b));
                    alu_op     = 2'(op);
                    funct3     = 3'(f);
                    funct7_b30 = 1'(b);
                    alu_src    = 1'b0;
                    rs1_data   = 64'(op * 16 + f * 2 + b);
                    step();
                    chk($sformatf("sweep_%0d_%0d_%0d_ctl", op, f, b), out_control, e[4:1]);
                    chk($sformatf("sweep_%0d_%0d_%0d_ill", op, f, b), out_illegal, e[0]);
                end
        in_valid = 1'b0;
        step();
        chk("drain_out_valid", out_valid, 0);

        // Back-pressure: third push held while full, order preserved
        alu_op = 2'b00; alu_src = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b1; rs1_data = 64'd1;
        step();
        chk("bp1_in_ready", in_ready, 1);
        chk("bp1_a", out_a, 1);
        rs1_data = 64'd2;
        step();
        chk("bp2_in_ready", in_ready, 0);
        chk("bp2_a", out_a, 1);
        rs1_data = 64'd3;
        step();
        chk("bp3_in_ready", in_ready, 0);
        chk("bp3_a_stable", out_a, 1);
        chk("bp3_valid", out_valid, 1);
        out_ready = 1'b1;
        step();
        chk("bp4_a", out_a, 2);
        chk("bp4_in_ready", in_ready, 1);
        step();
        chk("bp5_a", out_a, 3);
        in_valid = 1'b0;
        step();
        chk("bp6_out_valid", out_valid, 0);

        // Simultaneous push/pop streaming
        in_valid = 1'b1; out_ready = 1'b1; rs1_data = 64'd0;
        step();
        for (int k = 1; k <= 20; k++) begin
            rs1_data = 64'(k);
            #1;
            chk($sformatf("stream%0d_in_ready", k), in_ready, 1);
            chk($sformatf("stream%0d_a", k), out_a, 64'(k - 1));
            step();
        end
        chk("stream_last_a", out_a, 20);
        in_valid = 1'b0;
        step();
        chk("stream_drain", out_valid, 0);

`ifdef ALU_ISSUE_PERF_EN
        // 7 stalled cycles then 5 pops
        issue_base = issue_count;
        stall_base = stall_count;
        out_ready = 1'b0; in_valid = 1'b1; rs1_data = 64'd100;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) step();
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rs1_data = 64'(101 + i);
            step();
        end
        in_valid = 1'b0;
        step();
        chk("perf_issue", issue_count - issue_base, 5);
        chk("perf_stall", stall_count - stall_base, 7);
`endif

        // Asynchronous reset while FULL discards both entries
        out_ready = 1'b0; in_valid = 1'b1;
        rs1_data = 64'hAAAA;
        step();
        rs1_data = 64'hBBBB;
        step();
        chk("full_in_ready", in_ready, 0);
        chk("full_out_valid", out_valid, 1);
        reset_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_a", out_a, 0);
`ifdef ALU_ISSUE_PERF_EN
        chk("arst_issue_count", issue_count, 0);
        chk("arst_stall_count", stall_count, 0);
`endif
        step();
        reset_n = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("post_rst_out_valid", out_valid, 0);
        chk("post_rst_a", out_a, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
